// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, bit-period helper
// and parity mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int unsigned PARITY_EVEN     = 0;
    localparam int unsigned PARITY_ODD_MODE = 1;

    function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO; a write that finds it full is dropped (and flagged
// for one clock) unless a pop in the same cycle frees a slot.
module uart_rx_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= wr_en && !do_wr;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits (PARITY_ODD: 0 even, 1 odd).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
`ifdef UART_RX_PARITY_EN
    parameter int unsigned PARITY_ODD = PARITY_EVEN,
`endif
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_rxd,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    output logic [DATA_BITS-1:0]        o_rx_data,
    output logic                        o_frame_err,
    output logic                        o_parity_err,
    output logic                        o_overrun,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int unsigned CPB   = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam int unsigned ENTRY_W = DATA_BITS + 2;
    localparam logic        ODD     = (PARITY_ODD == PARITY_ODD_MODE);
`else
    localparam int unsigned ENTRY_W = DATA_BITS + 1;
`endif

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(CPB / 2);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(CPB / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 s0;
    logic                 s1;
    logic                 vote;
    logic                 at_vote;
    logic                 at_end;
    logic                 cnt_clr;
    logic                 frame_done;
    logic [DATA_BITS-1:0] shreg;
    logic                 wr_en;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   head;
    logic                 fifo_empty;
    logic                 pop;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 parity_err_bit;

    assign parity_err_bit = par_bit ^ (^shreg) ^ ODD;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rxd;
            rx_sync <= rx_meta;
        end
    end

    // Earlier two samples are latched; the third is the live synchronized value.
    assign vote    = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
    assign at_vote = (clk_cnt == CNT_VOTE);
    assign at_end  = (clk_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_next = START;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_next = IDLE;
                end else if (at_end) begin
                    state_next = DATA;
                    cnt_clr    = 1'b1;
                end
            end
            DATA: begin
                if (at_end) begin
                    cnt_clr = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (at_end) begin
                    state_next = STOP;
                    cnt_clr    = 1'b1;
                end
            end
            STOP: begin
                if (at_vote) begin
                    frame_done = 1'b1;
                    state_next = vote ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            shreg    <= '0;
            wr_en    <= 1'b0;
            wr_entry <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            if (cnt_clr || state == IDLE || state == WAIT_HIGH) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (clk_cnt == CNT_S0) begin
                s0 <= rx_sync;
            end
            if (clk_cnt == CNT_S1) begin
                s1 <= rx_sync;
            end
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (state == DATA && at_end) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == DATA && at_vote) begin
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && at_vote) begin
                par_bit <= vote;
            end
`endif
            // Entry is registered here and written into the FIFO on the next clock.
            wr_en <= frame_done;
            if (frame_done) begin
`ifdef UART_RX_PARITY_EN
                wr_entry <= {parity_err_bit, ~vote, shreg};
`else
                wr_entry <= {~vote, shreg};
`endif
            end
        end
    end

    uart_rx_sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (o_fifo_count),
        .empty   (fifo_empty),
        .overflow(o_overrun)
    );

    assign o_rx_valid  = !fifo_empty;
    assign pop         = o_rx_valid && i_rx_ready;
    assign o_rx_data   = o_rx_valid ? head[DATA_BITS-1:0] : '0;
    assign o_frame_err = o_rx_valid & head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = o_rx_valid & head[DATA_BITS+1];
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, which SHALL be at least 8.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, a power of two and at least 2.
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port i_rxd  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port o_rx_valid  output  1  FIFO head entry is valid.
REQ-009 SHALL have port i_rx_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port o_rx_data  output  DATA_BITS  head entry data, LSB first on the line.
REQ-011 SHALL have port o_frame_err  output  1  head entry had a low stop bit.
REQ-012 SHALL have port o_parity_err  output  1  head entry failed parity; constant 0 without the parity macro.
REQ-013 SHALL have port o_overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port o_fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL pass i_rxd through a two-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-016 SHALL sample each bit by majority vote of 3 samples taken at clock offsets CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1 from the bit start.
REQ-017 SHALL use the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-018 IDLE SHALL go to START on a synchronized low and restart the bit counter at 0.
REQ-019 START SHALL go to DATA if the majority vote is 0, and SHALL otherwise return to IDLE as a glitch, writing nothing.
REQ-020 DATA SHALL capture DATA_BITS votes LSB first, then go to PARITY if parity is compiled in, otherwise to STOP.
REQ-021 STOP SHALL vote the stop bit at mid-bit, commit the frame to the FIFO, then go to IDLE if the vote is 1, or to WAIT_HIGH with the frame error flag set if it is 0.
REQ-022 WAIT_HIGH SHALL stay until the synchronized line is high, then go to IDLE, so that a break yields exactly one entry.
REQ-023 SHALL store each entry as data, frame error flag and parity error flag, and SHALL write it in the clock after the stop vote; o_rx_valid SHALL rise in the following clock.
REQ-024 The FIFO SHALL be show-ahead: a pop occurs on o_rx_valid && i_rx_ready, and the next entry SHALL appear in the next clock.
REQ-025 A write to a full FIFO with no pop in the same cycle SHALL drop the new frame and pulse o_overrun for exactly one clock.
REQ-026 A write and a pop in the same cycle to a full FIFO SHALL both succeed, with no overrun and unchanged count.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_count SHALL never exceed FIFO_DEPTH.
REQ-028 When o_rx_valid is 0, o_rx_data and the error flags SHALL be don't-care for the consumer.

Reset
REQ-029 While i_rst_n is low at a clock edge, the receiver SHALL go to IDLE and the counters, FIFO pointers and count SHALL clear.
REQ-030 While i_rst_n is low at a clock edge, o_rx_valid, o_overrun, o_frame_err, o_parity_err and o_rx_data SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame, and any stored entries SHALL be lost.

Configuration
REQ-032 Macro UART_RX_PARITY_EN SHALL add parameter PARITY_ODD, default 0 (0 = even, 1 = odd), and the PARITY state expecting one parity bit after the data bits.
REQ-033 With UART_RX_PARITY_EN defined, the parity error flag SHALL be set when the voted parity does not match the data; without it, no parity bit is expected and o_parity_err SHALL be tied to 0.

Structure
REQ-034 Package uart_pkg SHALL hold the state encoding, a CLKS_PER_BIT helper and the parity mode constants.
REQ-035 The FIFO SHALL be the sub-module uart_rx_sync_fifo, parametrised by width and depth.

Verification
REQ-036 With 50 MHz, 9600 baud and 8N1 defaults, frame 0xA5 with ready held high SHALL give one o_rx_valid pulse with data 0xA5 and both error flags 0.
REQ-037 A 1000-clock low glitch on an idle line SHALL write no entry and leave o_fifo_count at 0.
REQ-038 Frame 0x3C with a low stop bit held low for 3 bit times SHALL give exactly one entry with data 0x3C and o_frame_err 1, then correct reception of the next frame 0x55.
REQ-039 With ready low, FIFO_DEPTH 4 and 5 frames 0x01..0x05 sent, the bench SHALL see count 4, one o_overrun pulse, and pops returning 0x01..0x04 only.
REQ-040 With UART_RX_PARITY_EN and PARITY_ODD 0, frame 0x07 with parity 0 SHALL be received as 0x07 with o_parity_err 1.
REQ-041 Reset asserted during data bit 3 SHALL leave the FIFO empty, and the next full frame 0x81 SHALL be received correctly.
